// File: rtl/life_scan_reader.sv
// Unloads the life_cell scan chain tail-first and packs the serial stream into
// WORD-bit words offered on a valid/ready port; optional recirculation preserves the board.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | chain frozen, waiting for start
// SHIFT   | scan=1, one cell per edge captured into data[bitcnt]
// PRESENT | chain frozen, word offered until data_ready
// DONE    | one-cycle done pulse, then back to IDLE
module life_scan_reader #(
  parameter int CELLS = 64,
  parameter int WORD  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            recirc,
  input  logic            chain_tail,
  output logic            scan,
  output logic            scan_val,
  output logic            gen_hold,
  output logic            busy,
  output logic [WORD-1:0] data,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            data_last,
  output logic            done
);

  localparam int NWORDS = CELLS / WORD;
  localparam int BW     = (WORD > 1) ? $clog2(WORD) : 1;
  localparam int WW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   bitcnt, bitcnt_nx;
  logic [WW-1:0]   wordcnt, wordcnt_nx;
  logic [WORD-1:0] data_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      bitcnt  <= '0;
      wordcnt <= '0;
      data    <= '0;
    end else begin
      state   <= state_nx;
      bitcnt  <= bitcnt_nx;
      wordcnt <= wordcnt_nx;
      data    <= data_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bitcnt_nx  = bitcnt;
    wordcnt_nx = wordcnt;
    data_nx    = data;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx   = S_SHIFT;
          bitcnt_nx  = '0;
          wordcnt_nx = '0;
        end
      end
      S_SHIFT: begin
        // tail value is sampled before this edge advances the chain
        data_nx[bitcnt] = chain_tail;
        if (bitcnt == BIT_LAST) begin
          state_nx = S_PRESENT;
        end else begin
          bitcnt_nx = bitcnt + 1'b1;
        end
      end
      S_PRESENT: begin
        if (data_ready) begin
          if (wordcnt == WORD_LAST) begin
            state_nx = S_DONE;
          end else begin
            state_nx   = S_SHIFT;
            wordcnt_nx = wordcnt + 1'b1;
            bitcnt_nx  = '0;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign scan       = (state == S_SHIFT);
  assign scan_val   = recirc ? chain_tail : 1'b0;
  assign busy       = (state != S_IDLE);
  assign gen_hold   = busy;
  assign data_valid = (state == S_PRESENT);
  assign data_last  = (state == S_PRESENT) && (wordcnt == WORD_LAST);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_life_scan_reader.sv
// Self-checking bench for life_scan_reader: 16-cell behavioural chain, table-driven
// unloads, hand-written reset sequences and randomized unloads against a mapping model.
module tb_life_scan_reader;

  localparam int CELLS = 16;
  localparam int WORD  = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic            recirc;
  logic            chain_tail;
  logic            scan;
  logic            scan_val;
  logic            gen_hold;
  logic            busy;
  logic [WORD-1:0] data;
  logic            data_valid;
  logic            data_ready;
  logic            data_last;
  logic            done;

  logic [CELLS-1:0] chain;
  logic             load_en;
  logic [CELLS-1:0] load_val;

  int vectors;
  int miscompares;

  life_scan_reader #(.CELLS(CELLS), .WORD(WORD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .recirc     (recirc),
    .chain_tail (chain_tail),
    .scan       (scan),
    .scan_val   (scan_val),
    .gen_hold   (gen_hold),
    .busy       (busy),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_last  (data_last),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural chain: position 0 is the head, position CELLS-1 the tail
  always @(posedge clk) begin
    if (load_en) chain <= load_val;
    else if (scan) chain <= {chain[CELLS-2:0], scan_val};
  end
  assign chain_tail = chain[CELLS-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // word k, bit i = cell CELLS-1-(k*WORD+i) of the pre-start board
  function automatic logic [WORD-1:0] model_word(input logic [CELLS-1:0] board, input int k);
    logic [WORD-1:0] w;
    for (int i = 0; i < WORD; i++) w[i] = board[CELLS-1-(k*WORD+i)];
    return w;
  endfunction

  typedef struct {
    logic [CELLS-1:0] init;
    logic             rc;
    int               stall_word;
    int               stall_n;
    logic             extra_start;
    logic [WORD-1:0]  w0;
    logic [WORD-1:0]  w1;
    logic [CELLS-1:0] fin;
    int               done_t;
  } vec_t;

  vec_t tbl[5];

  task automatic load_chain(input logic [CELLS-1:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(posedge clk); #1;
    load_en  = 1'b0;
  endtask

  task automatic run_unload(input string tag, input logic [CELLS-1:0] init, input logic rc,
                            input int stall_word, input int stall_n, input logic extra_start,
                            input logic [WORD-1:0] w0, input logic [WORD-1:0] w1,
                            input logic [CELLS-1:0] fin, input int done_t);
    logic [WORD-1:0] got_w[$];
    logic            got_l[$];
    int              t, t_done, n_done, stalled;
    logic            prev_hold;
    logic [WORD-1:0] prev_data;
    load_chain(init);
    recirc     = rc;
    data_ready = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    t       = 0;
    t_done  = -1;
    n_done  = 0;
    stalled = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    while (t < 100 && !(t_done >= 0 && t > t_done)) begin
      @(posedge clk); #1;
      t++;
      start = (extra_start && t == 3);
      if (prev_hold) begin
        chk({tag, " held_valid"}, {31'd0, data_valid}, 32'd1);
        chk({tag, " held_data"}, {24'd0, data}, {24'd0, prev_data});
      end
      if (data_valid) begin
        chk({tag, " scan_in_present"}, {31'd0, scan}, 32'd0);
        if (got_w.size() == stall_word && stalled < stall_n) begin
          data_ready = 1'b0;
          stalled++;
        end else begin
          data_ready = 1'b1;
        end
        if (data_ready) begin
          got_w.push_back(data);
          got_l.push_back(data_last);
        end
      end else begin
        data_ready = 1'b1;
      end
      prev_hold = data_valid && !data_ready;
      prev_data = data;
      if (done) begin
        n_done++;
        if (t_done < 0) t_done = t;
      end
    end
    start = 1'b0;
    chk({tag, " busy_after_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " gen_hold_after_done"}, {31'd0, gen_hold}, 32'd0);
    chk({tag, " done_count"}, n_done, 32'd1);
    chk({tag, " done_time"}, t_done, done_t);
    chk({tag, " word_count"}, got_w.size(), 32'd2);
    if (got_w.size() == 2) begin
      chk({tag, " word0"}, {24'd0, got_w[0]}, {24'd0, w0});
      chk({tag, " word1"}, {24'd0, got_w[1]}, {24'd0, w1});
      chk({tag, " last_flags"}, {30'd0, got_l[0], got_l[1]}, 32'd1);
    end
    chk({tag, " final_chain"}, {16'd0, chain}, {16'd0, fin});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " scan"}, {31'd0, scan}, 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " gen_hold"}, {31'd0, gen_hold}, 32'd0);
    chk({tag, " valid"}, {31'd0, data_valid}, 32'd0);
    chk({tag, " last"}, {31'd0, data_last}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " data"}, {24'd0, data}, 32'd0);
  endtask

  initial begin
    logic [CELLS-1:0] rnd, rot3;
    logic             rrc;
    int               sw, sn;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    recirc      = 1'b0;
    data_ready  = 1'b0;
    load_en     = 1'b0;
    load_val    = '0;

    tbl[0] = '{16'hA5C3, 1'b1, 0, 0, 1'b0, 8'hA5, 8'hC3, 16'hA5C3, 18};
    tbl[1] = '{16'hA5C3, 1'b1, 0, 5, 1'b0, 8'hA5, 8'hC3, 16'hA5C3, 23};
    tbl[2] = '{16'hFFFF, 1'b0, 0, 0, 1'b0, 8'hFF, 8'hFF, 16'h0000, 18};
    tbl[3] = '{16'hA5C3, 1'b1, 0, 0, 1'b1, 8'hA5, 8'hC3, 16'hA5C3, 18};
    tbl[4] = '{16'h1234, 1'b1, 1, 2, 1'b0, 8'h48, 8'h2C, 16'h1234, 20};

    @(posedge clk); @(posedge clk); #1;
    chk_idle_outputs("reset");
    reset = 1'b1;

    for (int v = 0; v < 5; v++)
      run_unload($sformatf("vec%0d", v), tbl[v].init, tbl[v].rc, tbl[v].stall_word,
                 tbl[v].stall_n, tbl[v].extra_start, tbl[v].w0, tbl[v].w1,
                 tbl[v].fin, tbl[v].done_t);

    // reset during activity for two edges, then a clean unload
    load_chain(16'hA5C3);
    recirc = 1'b1; data_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_idle_outputs("reset_active");
    reset = 1'b1;
    run_unload("after_reset", 16'hA5C3, 1'b1, 0, 0, 1'b0, 8'hA5, 8'hC3, 16'hA5C3, 18);

    // reset lands on the third shift edge: chain ends rotated by three
    load_chain(16'hA5C3);
    rot3 = 16'h2E1D;
    recirc = 1'b1; data_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midshift scan", {31'd0, scan}, 32'd0);
    chk("midshift busy", {31'd0, busy}, 32'd0);
    chk("midshift valid", {31'd0, data_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midshift chain", {16'd0, chain}, {16'd0, rot3});
    run_unload("midshift_restart", rot3, 1'b1, 0, 0, 1'b0,
               model_word(rot3, 0), model_word(rot3, 1), rot3, 18);

    for (int r = 0; r < 20; r++) begin
      rnd = 16'($urandom);
      rrc = 1'($urandom_range(0, 1));
      sw  = $urandom_range(0, 1);
      sn  = $urandom_range(0, 4);
      run_unload($sformatf("rand%0d", r), rnd, rrc, sw, sn, 1'($urandom_range(0, 1)),
                 model_word(rnd, 0), model_word(rnd, 1), rrc ? rnd : '0, 18 + sn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
